// File: rtl/nearest_centroid_seq_if.sv
// Bus bundle for nearest_centroid_seq: centroid writes, point/result handshakes
// and the operand/result wires of the shared external distance unit.
interface nearest_centroid_seq_if #(
  parameter int dim        = 3,
  parameter int data_range = 255,
  parameter int k          = 8
);
  localparam int DS = $clog2(data_range);
  localparam int DW = $clog2(data_range * dim);
  localparam int IW = $clog2(k);
  localparam int PW = dim * DS;

  logic          cent_wr_en;
  logic [IW-1:0] cent_wr_addr;
  logic [PW-1:0] cent_wr_data;
  logic          point_valid;
  logic          point_ready;
  logic [PW-1:0] point;
  logic [PW-1:0] dist_a;
  logic [PW-1:0] dist_b;
  logic [DW-1:0] dist_in;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] result_idx;
  logic [DW-1:0] result_dist;
  logic          busy;

  modport master (
    output cent_wr_en, cent_wr_addr, cent_wr_data, point_valid, point, dist_in, result_ready,
    input  point_ready, dist_a, dist_b, result_valid, result_idx, result_dist, busy
  );

  modport slave (
    input  cent_wr_en, cent_wr_addr, cent_wr_data, point_valid, point, dist_in, result_ready,
    output point_ready, dist_a, dist_b, result_valid, result_idx, result_dist, busy
  );
endinterface

// File: rtl/nearest_centroid_seq.sv
// Sequential nearest-centroid search over k stored centroids via an external distance unit.
// Optional macro NCS_EARLY_EXIT_EN: an exact hit (distance 0) ends the scan early.
module ncs_slot #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end
endmodule

module nearest_centroid_seq #(
  parameter int dim        = 3,
  parameter int data_range = 255,
  parameter int k          = 8
) (
  input logic                  clk,
  input logic                  rst,
  nearest_centroid_seq_if.slave bus
);
  localparam int DS = $clog2(data_range);
  localparam int DW = $clog2(data_range * dim);
  localparam int IW = $clog2(k);
  localparam int PW = dim * DS;
  localparam logic [IW-1:0] LAST = IW'(k - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [k-1:0][PW-1:0] cent;
  logic [PW-1:0]        point_reg;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        best_idx;
  logic [DW-1:0]        best_dist;
  logic                 accept, wr_ok, last, hit, take;

  assign accept = (state == IDLE) && bus.point_valid;
  assign wr_ok  = (state == IDLE) && bus.cent_wr_en;
  assign last   = (idx == LAST);

`ifdef NCS_EARLY_EXIT_EN
  assign hit = (bus.dist_in == '0);
`else
  assign hit = 1'b0;
`endif

  // First slot seeds best unconditionally; later slots need a strictly smaller distance.
  assign take = (idx == '0) || (bus.dist_in < best_dist) || hit;

  genvar g;
  generate
    for (g = 0; g < k; g++) begin : g_slot
      ncs_slot #(.W(PW)) u_slot (
        .clk (clk),
        .rst (rst),
        .we  (wr_ok && (bus.cent_wr_addr == IW'(g))),
        .d   (bus.cent_wr_data),
        .q   (cent[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.point_ready  = 1'b0;
    bus.result_valid = 1'b0;
    bus.busy         = 1'b0;
    bus.dist_a       = '0;
    bus.dist_b       = '0;
    case (state)
      IDLE: begin
        bus.point_ready = 1'b1;
        if (bus.point_valid) state_nxt = SCAN;
      end
      SCAN: begin
        bus.busy   = 1'b1;
        bus.dist_a = point_reg;
        bus.dist_b = cent[idx];
        if (last || hit) state_nxt = DONE;
      end
      DONE: begin
        bus.busy         = 1'b1;
        bus.result_valid = 1'b1;
        if (bus.result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.result_idx  = best_idx;
  assign bus.result_dist = best_dist;

  // Index parks at k-1 on the final slot; it is only re-cleared by the next acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      point_reg <= '0;
      idx       <= '0;
      best_idx  <= '0;
      best_dist <= '0;
    end else begin
      if (accept) begin
        point_reg <= bus.point;
        idx       <= '0;
      end
      if (state == SCAN) begin
        if (take) begin
          best_dist <= bus.dist_in;
          best_idx  <= idx;
        end
        if (!last) idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nearest_centroid_seq.sv
// Directed bench for nearest_centroid_seq with k = 4 and a behavioural Manhattan distance unit.
module tb_nearest_centroid_seq;
  localparam int DIM = 3;
  localparam int RNG = 255;
  localparam int K   = 4;
  localparam int DS  = 8;
  localparam int DW  = 10;
  localparam int IW  = 2;
  localparam int PW  = DIM * DS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  nearest_centroid_seq_if #(.dim(DIM), .data_range(RNG), .k(K)) bus ();

  nearest_centroid_seq #(.dim(DIM), .data_range(RNG), .k(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pk(input int x, input int y, input int z);
    return {8'(z), 8'(y), 8'(x)};
  endfunction

  function automatic logic [DW-1:0] manhattan(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int s;
    int x;
    int y;
    s = 0;
    for (int c = 0; c < DIM; c++) begin
      x = int'(a[c*DS +: DS]);
      y = int'(b[c*DS +: DS]);
      s = s + ((x > y) ? (x - y) : (y - x));
    end
    return DW'(s);
  endfunction

  assign bus.dist_in = manhattan(bus.dist_a, bus.dist_b);

  task automatic write_cent(input int addr, input logic [PW-1:0] data);
    @(negedge clk);
    bus.cent_wr_en   = 1'b1;
    bus.cent_wr_addr = IW'(addr);
    bus.cent_wr_data = data;
    @(negedge clk);
    bus.cent_wr_en   = 1'b0;
  endtask

  task automatic load_default();
    write_cent(0, pk(0, 0, 0));
    write_cent(1, pk(10, 10, 10));
    write_cent(2, pk(40, 40, 40));
    write_cent(3, pk(80, 80, 80));
  endtask

  // Returns at the negedge just after the acceptance edge (scan slot 0 on the wires).
  task automatic offer_point(input logic [PW-1:0] p);
    @(negedge clk);
    bus.point       = p;
    bus.point_valid = 1'b1;
    @(negedge clk);
    bus.point_valid = 1'b0;
  endtask

  task automatic wait_result(input int max, output int n);
    n = 0;
    while (!bus.result_valid && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.point_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.point_ready); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.result_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.result_idx !== 2'd0 || bus.result_dist !== 10'd0) begin errors++; $display("FAIL reset_result: got idx=%0d dist=%0d want 0/0", bus.result_idx, bus.result_dist); end
    checks++; if (bus.dist_a !== '0 || bus.dist_b !== '0) begin errors++; $display("FAIL reset_dist_ops: got a=%h b=%h want 0", bus.dist_a, bus.dist_b); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.point_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.point_ready); end
  endtask

  task automatic test_basic();
    int n;
    offer_point(pk(12, 9, 10));
    checks++; if (bus.busy !== 1'b1 || bus.point_ready !== 1'b0) begin errors++; $display("FAIL basic_scan_flags: got busy=%b ready=%b want 1/0", bus.busy, bus.point_ready); end
    checks++; if (bus.dist_a !== pk(12, 9, 10)) begin errors++; $display("FAIL basic_dist_a: got %h want %h", bus.dist_a, pk(12, 9, 10)); end
    @(negedge clk);
    checks++; if (bus.dist_b !== pk(10, 10, 10)) begin errors++; $display("FAIL basic_dist_b1: got %h want %h", bus.dist_b, pk(10, 10, 10)); end
    wait_result(20, n);
    checks++; if (n + 1 != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", n + 1); end
    checks++; if (bus.result_idx !== 2'd1 || bus.result_dist !== 10'd3) begin errors++; $display("FAIL basic_result: got idx=%0d dist=%0d want 1/3", bus.result_idx, bus.result_dist); end
    checks++; if (bus.dist_a !== '0 || bus.dist_b !== '0) begin errors++; $display("FAIL done_dist_ops: got a=%h b=%h want 0", bus.dist_a, bus.dist_b); end
    consume();
    checks++; if (bus.point_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_back_idle: got ready=%b busy=%b want 1/0", bus.point_ready, bus.busy); end
  endtask

  task automatic test_hold();
    int n;
    offer_point(pk(41, 40, 40));
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    wait_result(20, n);
    checks++; if (n + 2 != 4) begin errors++; $display("FAIL hold_latency: got %0d want 4", n + 2); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result_idx !== 2'd2 || bus.result_dist !== 10'd1 || bus.point_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b idx=%0d dist=%0d ready=%b want 1/2/1/0", i, bus.result_valid, bus.result_idx, bus.result_dist, bus.point_ready);
      end
    end
    consume();
    checks++; if (bus.point_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL hold_release: got ready=%b v=%b busy=%b want 1/0/0", bus.point_ready, bus.result_valid, bus.busy); end
  endtask

  task automatic test_zero();
    int n;
    int want;
`ifdef NCS_EARLY_EXIT_EN
    want = 2;
`else
    want = 4;
`endif
    offer_point(pk(10, 10, 10));
    wait_result(20, n);
    checks++; if (n != want) begin errors++; $display("FAIL zero_latency: got %0d want %0d", n, want); end
    checks++; if (bus.result_idx !== 2'd1 || bus.result_dist !== 10'd0) begin errors++; $display("FAIL zero_result: got idx=%0d dist=%0d want 1/0", bus.result_idx, bus.result_dist); end
    consume();
  endtask

  task automatic test_tie();
    int n;
    write_cent(1, pk(5, 5, 5));
    @(negedge clk);
    bus.cent_wr_en   = 1'b1;
    bus.cent_wr_addr = 2'd0;
    bus.cent_wr_data = pk(5, 5, 5);
    bus.point        = pk(6, 5, 5);
    bus.point_valid  = 1'b1;
    @(negedge clk);
    bus.cent_wr_en   = 1'b0;
    bus.point_valid  = 1'b0;
    wait_result(20, n);
    checks++; if (n >= 20) begin errors++; $display("FAIL tie_timeout: got no result within %0d cycles", n); end
    checks++; if (bus.result_idx !== 2'd0 || bus.result_dist !== 10'd1) begin errors++; $display("FAIL tie_result: got idx=%0d dist=%0d want 0/1", bus.result_idx, bus.result_dist); end
    consume();
    write_cent(0, pk(0, 0, 0));
    write_cent(1, pk(10, 10, 10));
  endtask

  task automatic test_drop_write();
    int n;
    offer_point(pk(40, 40, 40));
    write_cent(3, pk(0, 0, 0));
    wait_result(20, n);
    checks++; if (bus.result_idx !== 2'd2 || bus.result_dist !== 10'd0) begin errors++; $display("FAIL drop_first: got idx=%0d dist=%0d want 2/0", bus.result_idx, bus.result_dist); end
    write_cent(3, pk(0, 0, 0));
    consume();
    offer_point(pk(80, 80, 80));
    wait_result(20, n);
    checks++; if (bus.result_idx !== 2'd3 || bus.result_dist !== 10'd0) begin errors++; $display("FAIL drop_write: got idx=%0d dist=%0d want 3/0", bus.result_idx, bus.result_dist); end
    consume();
  endtask

  task automatic test_abort();
    int seen;
    offer_point(pk(80, 80, 80));
    repeat (2) @(negedge clk);
    checks++; if (bus.dist_b !== pk(40, 40, 40)) begin errors++; $display("FAIL abort_at_idx2: got b=%h want %h", bus.dist_b, pk(40, 40, 40)); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.point_ready !== 1'b1) begin errors++; $display("FAIL abort_state: got v=%b busy=%b ready=%b want 0/0/1", bus.result_valid, bus.busy, bus.point_ready); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.result_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    bus.cent_wr_en   = 1'b0;
    bus.cent_wr_addr = '0;
    bus.cent_wr_data = '0;
    bus.point_valid  = 1'b0;
    bus.point        = '0;
    bus.result_ready = 1'b0;
    test_reset();
    load_default();
    test_basic();
    test_hold();
    test_zero();
    test_tie();
    test_drop_write();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
